// File: rtl/layer_pkg.sv
// Shared types and default sizing for the argmax sink layer.
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam int DEF_M = 16;
    localparam int DEF_T = 16;

endpackage

// File: rtl/vec_argmax_sink_if.sv
// Stream-in / result-out bundle for vec_argmax_sink; slave is the sink, master the environment.
interface vec_argmax_sink_if
    import layer_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int T = DEF_T
);
    localparam int logM = $clog2(M + 1);

    logic                   s_valid;
    logic                   s_ready;
    logic signed [T-1:0]    data_in;
    logic                   m_valid;
    logic                   m_ready;
    logic [logM-1:0]        max_idx;
    logic signed [T-1:0]    max_val;

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, max_idx, max_val
    );

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, max_idx, max_val
    );

endinterface

// File: rtl/argmax_cmp.sv
// Signed candidate-vs-current compare; ARGMAX_TIE_LAST_EN makes ties go to the later word.
module argmax_cmp #(
    parameter int T = 16
) (
    input  logic signed [T-1:0] cand,
    input  logic signed [T-1:0] cur,
    output logic                take
);

`ifdef ARGMAX_TIE_LAST_EN
    assign take = (cand >= cur);
`else
    assign take = (cand > cur);
`endif

endmodule

// File: rtl/vec_argmax_sink.sv
// Collects M signed words and presents the position/value of the largest one.
// Tie-break selected by ARGMAX_TIE_LAST_EN (see argmax_cmp).
module vec_argmax_sink
    import layer_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int T = DEF_T
) (
    input  logic               clk,
    input  logic               reset,
    vec_argmax_sink_if.slave   bus
);

    localparam int logM = $clog2(M + 1);

    state_e                 state_q, state_d;
    logic [logM-1:0]        count_q, count_d;
    logic [logM-1:0]        max_idx_q, max_idx_d;
    logic signed [T-1:0]    max_val_q, max_val_d;
    logic                   s_ready_q;
    logic                   m_valid_q;
    logic                   xfer;
    logic                   take;

    assign xfer = bus.s_valid && s_ready_q;

    argmax_cmp #(.T(T)) u_cmp (
        .cand (bus.data_in),
        .cur  (max_val_q),
        .take (take)
    );

    // The running max doubles as the output register: it only moves while m_valid is low.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;

        if (xfer) begin
            if (count_q == '0 || take) begin
                max_val_d = bus.data_in;
                max_idx_d = count_q;
            end
            count_d = count_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (xfer) state_d = COLLECT;
            end
            COLLECT: begin
                if (xfer && count_q == logM'(M - 1)) begin
                    state_d = PRESENT;
                    count_d = '0;
                end
            end
            PRESENT: begin
                if (m_valid_q && bus.m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
            s_ready_q <= (state_d != PRESENT);
            m_valid_q <= (state_d == PRESENT);
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.max_idx = max_idx_q;
    assign bus.max_val = max_val_q;

endmodule

// File: tb/tb_vec_argmax_sink.sv
// Directed + randomized bench for vec_argmax_sink; honours ARGMAX_TIE_LAST_EN in its reference model.
module tb_vec_argmax_sink;
    import layer_pkg::*;

    localparam int M = 16;
    localparam int T = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic signed [T-1:0] vec [M];

    vec_argmax_sink_if #(.M(M), .T(T)) bus();

    vec_argmax_sink #(.M(M), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: find the vector maximum, then the first (or last) position holding it.
    function automatic void refArgmax(output int idx, output int val);
        int maxv;
        maxv = vec[0];
        for (int i = 1; i < M; i++) if (vec[i] > maxv) maxv = vec[i];
        idx = -1;
        for (int i = 0; i < M; i++) begin
            if (vec[i] == maxv) begin
`ifdef ARGMAX_TIE_LAST_EN
                idx = i;
`else
                if (idx < 0) idx = i;
`endif
            end
        end
        val = maxv;
    endfunction

    task automatic sendWord(input logic signed [T-1:0] v);
        int n;
        bus.s_valid = 1'b1;
        bus.data_in = v;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) checkOutput("s_ready_wait", bus.s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit gaps, input int nWords);
        for (int i = 0; i < nWords; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                bus.s_valid = 1'b0;
                bus.data_in = T'($urandom);
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
            sendWord(vec[i]);
        end
    endtask

    // Called #1 after the M-th transfer; stalls, optionally offers an extra word, then handshakes.
    task automatic checkResult(input string tag, input int stall, input bit offerExtra);
        int ei, ev;
        refArgmax(ei, ev);
        checkOutput({tag, "_m_valid"}, bus.m_valid, 1);
        checkOutput({tag, "_max_idx"}, bus.max_idx, ei);
        checkOutput({tag, "_max_val"}, bus.max_val, ev);
        checkOutput({tag, "_s_ready_low"}, bus.s_ready, 0);
        if (offerExtra) begin
            bus.s_valid = 1'b1;
            bus.data_in = 16'sh7fff;
        end else begin
            bus.s_valid = 1'b0;
        end
        for (int c = 0; c < stall; c++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_stall_m_valid"}, bus.m_valid, 1);
            checkOutput({tag, "_stall_idx"}, bus.max_idx, ei);
            checkOutput({tag, "_stall_val"}, bus.max_val, ev);
            checkOutput({tag, "_stall_s_ready"}, bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        checkOutput({tag, "_m_valid_drop"}, bus.m_valid, 0);
        checkOutput({tag, "_s_ready_back"}, bus.s_ready, 1);
    endtask

    initial begin
        int r;
        int ei, ev;
        bus.s_valid = 1'b0;
        bus.data_in = '0;
        bus.m_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_s_ready", bus.s_ready, 0);
        checkOutput("rst_m_valid", bus.m_valid, 0);
        checkOutput("rst_max_idx", bus.max_idx, 0);
        checkOutput("rst_max_val", bus.max_val, 0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rel_s_ready_still_low", bus.s_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("rel_s_ready_rise", bus.s_ready, 1);

        for (int i = 0; i < M; i++) vec[i] = T'(i);
        applyStimulus(1'b0, M);
        checkResult("ramp", 0, 1'b0);

        for (int i = 0; i < M; i++) begin
            r = -int'($urandom_range(100, 2));
            vec[i] = T'(r);
        end
        vec[7] = -16'sd1;
        applyStimulus(1'b0, M);
        checkResult("neg", 0, 1'b0);

        for (int i = 0; i < M; i++) vec[i] = '0;
        applyStimulus(1'b0, M);
        checkResult("zeros", 0, 1'b0);

        for (int i = 0; i < M; i++) vec[i] = T'($urandom_range(1000, 0));
        applyStimulus(1'b0, M);
        checkResult("stall", 5, 1'b1);

        // Max away from position 0 so an absorbed extra word would show up here.
        for (int i = 0; i < M; i++) vec[i] = T'($urandom_range(500, 0));
        vec[0]  = -16'sd50;
        vec[11] = 16'sd900;
        bus.m_ready = 1'b1;
        applyStimulus(1'b0, M);
        refArgmax(ei, ev);
        checkOutput("pre_ready_m_valid", bus.m_valid, 1);
        checkOutput("pre_ready_max_idx", bus.max_idx, ei);
        checkOutput("pre_ready_max_val", bus.max_val, ev);
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        checkOutput("pre_ready_m_valid_drop", bus.m_valid, 0);
        checkOutput("pre_ready_s_ready", bus.s_ready, 1);

        for (int i = 0; i < M; i++) begin
            r = int'($urandom_range(598, 0)) - 299;
            vec[i] = T'(r);
        end
        vec[3] = 16'sd300;
        applyStimulus(1'b1, M);
        checkResult("gaps300", 2, 1'b0);
        for (int i = 0; i < M; i++) vec[i] = T'($urandom);
        applyStimulus(1'b1, M);
        checkResult("gaps_next", 1, 1'b0);

        for (int i = 0; i < M; i++) vec[i] = 16'sd30000;
        applyStimulus(1'b0, 10);
        bus.s_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_m_valid", bus.m_valid, 0);
        checkOutput("midrst_s_ready", bus.s_ready, 0);
        checkOutput("midrst_max_idx", bus.max_idx, 0);
        checkOutput("midrst_max_val", bus.max_val, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++) vec[i] = T'($urandom_range(2000, 0));
        vec[0] = -16'sd7;
        applyStimulus(1'b0, M);
        checkResult("after_rst", 0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < M; i++) vec[i] = T'($urandom_range(7, 0) - 4);
            applyStimulus(1'b1, M);
            checkResult("rand_ties", int'($urandom_range(2, 0)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_argmax_sink.md
VEC_ARGMAX_SINK -- requirements
Module: vec_argmax_sink

Interface
REQ-001 The block SHALL have parameter M, default 16, meaning words per output vector (M >= 2).
REQ-002 The block SHALL have parameter T, default 16, meaning word width in bits (signed).
REQ-003 The block SHALL have localparam logM = $clog2(M+1), meaning index/count width.
REQ-004 The block SHALL have port clk  in  1  meaning single clock; all flops rise on posedge clk.
REQ-005 The block SHALL have port reset  in  1  meaning reset, asynchronous, active-low.
REQ-006 The block SHALL have port s_valid  in  1  meaning an input word is offered.
REQ-007 The block SHALL have port s_ready  out  1  meaning the block accepts the offered word.
REQ-008 The block SHALL have port data_in  in  T  meaning signed input word (upstream layer data_out).
REQ-009 The block SHALL have port m_valid  out  1  meaning a result is presented.
REQ-010 The block SHALL have port m_ready  in  1  meaning the downstream consumer takes the result.
REQ-011 The block SHALL have port max_idx  out  logM  meaning position (0..M-1) of the maximum word in the vector.
REQ-012 The block SHALL have port max_val  out  T  meaning signed value of the maximum word.

Function
REQ-013 The block SHALL transfer an input word only on a posedge where s_valid && s_ready; a word is otherwise neither consumed nor counted.
REQ-014 The FSM SHALL have states IDLE, COLLECT and PRESENT.
REQ-015 Transitions SHALL be: IDLE->COLLECT on the first transfer; COLLECT->PRESENT on the transfer that makes the count equal M; PRESENT->IDLE on m_valid && m_ready; all other cycles hold.
REQ-016 s_ready SHALL be registered: 1 in IDLE and COLLECT, 0 in PRESENT.
REQ-017 s_ready SHALL return to 1 on the cycle after the result handshake.
REQ-018 The word counter SHALL increment on every transfer and clear to 0 on entering PRESENT.
REQ-019 On word 0 the running max SHALL load data_in with index 0, unconditionally.
REQ-020 On word k > 0 the running max SHALL be replaced when data_in is strictly greater (signed T-bit compare); ties SHALL follow REQ-030.
REQ-021 m_valid SHALL assert on the cycle after the M-th transfer (latency 1) and remain high, with max_idx/max_val stable, until m_ready is sampled high.
REQ-022 max_idx and max_val SHALL be registered outputs and SHALL change only when m_valid is low.
REQ-023 If s_valid drops mid-vector, the block SHALL hold its count and running max indefinitely; gaps SHALL not affect the result.
REQ-024 If m_ready is already high when m_valid rises, the handshake SHALL complete in that single cycle.

Reset
REQ-025 On reset low, asynchronously: state = IDLE, count = 0, s_ready = 0, m_valid = 0, max_idx = 0, max_val = 0.
REQ-026 s_ready SHALL rise on the first posedge after reset deasserts.
REQ-027 Reset asserted mid-vector or during PRESENT SHALL discard the partial vector or result; the next transfer after release SHALL be treated as word 0.

Configuration
REQ-028 The macro ARGMAX_TIE_LAST_EN SHALL select the tie-break rule.
REQ-029 When ARGMAX_TIE_LAST_EN is defined, the update condition SHALL be data_in >= running max, so the last equal index wins.
REQ-030 When ARGMAX_TIE_LAST_EN is not defined, the update condition SHALL be data_in > running max, so the first equal index wins.

Structure
REQ-031 Package layer_pkg SHALL hold the FSM state enum typedef and the default M and T constants.
REQ-032 Sub-module argmax_cmp SHALL hold the signed compare and tie rule, with inputs cand, cur and output take; it SHALL be instantiated once.

Verification
REQ-033 After reset release, a stream of 16 words 0..15 with s_valid held high SHALL produce m_valid one cycle after the last word, with max_idx = 15, max_val = 15.
REQ-034 A stream with all words negative (-5, -3, -9, ...) and the maximum -1 at position 7 SHALL produce max_idx = 7, max_val = -1 (signed compare check).
REQ-035 A stream of 16 zeros SHALL produce max_idx = 0 without the macro and max_idx = 15 with ARGMAX_TIE_LAST_EN.
REQ-036 With m_ready held low for 5 cycles, m_valid and outputs SHALL stay stable and s_ready = 0; a 17th word offered during that time SHALL not be accepted.
REQ-037 With random s_valid gaps (50%) and value 300 at position 3, the result SHALL be max_idx = 3, max_val = 300; a second vector SHALL follow with no lost words.
REQ-038 Reset pulsed after word 9, followed by a full 16-word vector, SHALL give a result computed from the new vector only.
